mem_access_unit: RTL and testbench

//  Sits directly upstream of the unified word memory (mem: write on rising clk when we=1, combinational rd).

---
 rtl/mem_access_unit.sv | 110 +++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Single-port arbiter in front of the unified word memory: data beats fetch, one access in flight.
// Request accepted in IDLE, memory accessed the next cycle, done pulses the cycle after that.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic [31:0] instr_o,
  output logic        f_done_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] rdata_o,
  output logic        d_done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic [31:0] mem_a_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STORE,
    S_RESP
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] instr_q;
  logic [31:0] rdata_q;
  logic        f_done_q;
  logic        d_done_q;
  logic        err_q;
  logic        in_range;

  assign in_range = (addr_q < MEM_LIMIT);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      instr_q  <= 32'd0;
      rdata_q  <= 32'd0;
      f_done_q <= 1'b0;
      d_done_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (d_req_i) begin
            addr_q  <= d_addr_i;
            wdata_q <= d_wdata_i;
            state_q <= d_we_i ? S_STORE : S_LOAD;
          end else if (f_req_i) begin
            addr_q  <= f_addr_i;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (in_range) instr_q <= mem_rd_i;
          f_done_q <= 1'b1;
          err_q    <= ~in_range;
          state_q  <= S_RESP;
        end
        S_LOAD: begin
          if (in_range) rdata_q <= mem_rd_i;
          d_done_q <= 1'b1;
          err_q    <= ~in_range;
          state_q  <= S_RESP;
        end
        S_STORE: begin
          d_done_q <= 1'b1;
          err_q    <= ~in_range;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          // Requester drops its request here, so nothing is sampled this cycle.
          f_done_q <= 1'b0;
          d_done_q <= 1'b0;
          err_q    <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reset gates the write so a STORE interrupted by reset never reaches memory.
  assign mem_we_o = (state_q == S_STORE) && in_range && !reset_i;
  assign mem_a_o  = addr_q;
  assign mem_wd_o = wdata_q;
  assign instr_o  = instr_q;
  assign rdata_o  = rdata_q;
  assign f_done_o = f_done_q;
  assign d_done_o = d_done_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-word behavioural memory attached.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic [31:0] instr;
  logic        f_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] rdata;
  logic        d_done;
  logic        err;
  logic        busy;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];
  int          we_cnt;
  logic [31:0] we_addr;
  int          n_chk;
  int          n_err;

  mem_access_unit #(.MEM_WORDS(64)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .f_req_i   (f_req),
    .f_addr_i  (f_addr),
    .instr_o   (instr),
    .f_done_o  (f_done),
    .d_req_i   (d_req),
    .d_we_i    (d_we),
    .d_addr_i  (d_addr),
    .d_wdata_i (d_wdata),
    .rdata_o   (rdata),
    .d_done_o  (d_done),
    .err_o     (err),
    .busy_o    (busy),
    .mem_a_o   (mem_a),
    .mem_we_o  (mem_we),
    .mem_wd_o  (mem_wd),
    .mem_rd_i  (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  assign mem_rd = (mem_a < 32'd64) ? mem[mem_a[5:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[5:0]] <= mem_wd;
      we_cnt  = we_cnt + 1;
      we_addr = mem_a;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Returns the number of negedges until the selected done pulse, 99 on timeout.
  task automatic wait_done(input bit is_data, output int n);
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if ((is_data && d_done) || (!is_data && f_done)) begin
        n = k;
        break;
      end
    end
    if (n == 0) n = 99;
  endtask

  task automatic data_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wd;
  endtask

  task automatic release_idle();
    d_req = 1'b0;
    f_req = 1'b0;
    @(negedge clk);
  endtask

  int n;
  int c0;

  initial begin
    n_chk = 0; n_err = 0; we_cnt = 0; we_addr = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = init_val(i);
    reset = 1'b1; f_req = 1'b0; f_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;

    repeat (2) @(negedge clk);
    check_val("rst_instr", instr, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_dones", {30'd0, f_done, d_done}, 32'd0);
    check_val("rst_mem_a", mem_a, 32'd0);
    reset = 1'b0;

    // Plain fetch
    f_req = 1'b1; f_addr = 32'd10;
    wait_done(1'b0, n);
    check_val("t1_latency", 32'(n), 32'd2);
    check_val("t1_instr", instr, init_val(10));
    check_val("t1_err", 32'(err), 32'd0);
    check_val("t1_no_d_done", 32'(d_done), 32'd0);
    release_idle();
    check_val("t1_pulse_len", 32'(f_done), 32'd0);
    check_val("t1_idle", 32'(busy), 32'd0);

    // Store then load back
    c0 = we_cnt;
    data_req(1'b1, 32'd25, 32'hABCD_1234);
    wait_done(1'b1, n);
    check_val("t2_st_latency", 32'(n), 32'd2);
    check_val("t2_we_count", 32'(we_cnt - c0), 32'd1);
    check_val("t2_we_addr", we_addr, 32'd25);
    check_val("t2_st_err", 32'(err), 32'd0);
    release_idle();
    data_req(1'b0, 32'd25, 32'd0);
    wait_done(1'b1, n);
    check_val("t2_ld_rdata", rdata, 32'hABCD_1234);
    release_idle();

    // Simultaneous fetch and load: load wins, fetch follows
    f_req = 1'b1; f_addr = 32'd5;
    data_req(1'b0, 32'd25, 32'd0);
    wait_done(1'b1, n);
    check_val("t3_d_first", 32'(n), 32'd2);
    check_val("t3_f_not_yet", 32'(f_done), 32'd0);
    d_req = 1'b0;
    wait_done(1'b0, n);
    check_val("t3_f_gap", 32'(n), 32'd3);
    check_val("t3_instr", instr, init_val(5));
    check_val("t3_rdata", rdata, 32'hABCD_1234);
    release_idle();

    // Out-of-range accesses
    c0 = we_cnt;
    data_req(1'b1, 32'd64, 32'h5555_AAAA);
    wait_done(1'b1, n);
    check_val("t4_st_latency", 32'(n), 32'd2);
    check_val("t4_st_err", 32'(err), 32'd1);
    check_val("t4_no_write", 32'(we_cnt - c0), 32'd0);
    check_val("t4_rdata_kept", rdata, 32'hABCD_1234);
    release_idle();
    check_val("t4_err_cleared", 32'(err), 32'd0);
    data_req(1'b0, 32'd63, 32'd0);
    wait_done(1'b1, n);
    check_val("t4_mem63", rdata, init_val(63));
    check_val("t4_ld63_err", 32'(err), 32'd0);
    release_idle();
    data_req(1'b0, 32'h8000_0019, 32'd0);
    wait_done(1'b1, n);
    check_val("t4_hi_err", 32'(err), 32'd1);
    check_val("t4_hi_rdata_kept", rdata, init_val(63));
    release_idle();

    // Reset during the STORE cycle
    c0 = we_cnt;
    data_req(1'b1, 32'd7, 32'h1111_2222);
    @(negedge clk);
    check_val("t5_in_store", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_val("t5_we_gated", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    d_req = 1'b0;
    check_val("t5_idle", 32'(busy), 32'd0);
    check_val("t5_no_write", 32'(we_cnt - c0), 32'd0);
    @(negedge clk);
    check_val("t5_no_done", 32'(d_done), 32'd0);
    data_req(1'b0, 32'd7, 32'd0);
    wait_done(1'b1, n);
    check_val("t5_old_value", rdata, init_val(7));
    release_idle();

    // Back-to-back loads with d_req held
    data_req(1'b0, 32'd3, 32'd0);
    wait_done(1'b1, n);
    check_val("t6_first_lat", 32'(n), 32'd2);
    check_val("t6_rdata3", rdata, init_val(3));
    d_addr = 32'd4;
    wait_done(1'b1, n);
    check_val("t6_gap", 32'(n), 32'd3);
    check_val("t6_rdata4", rdata, init_val(4));
    release_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
